// File: rtl/id_stage_pipe_pkg.sv
// Shared decode constants for the RV32 decode stage: opcodes, funct fields,
// ALU operation/result-select codes, reset/enable levels and the ID FSM states.
package id_stage_pipe_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SR      = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [7:0] ALU_NOP    = 8'h00;
   localparam logic [7:0] ALU_ADD    = 8'h01;
   localparam logic [7:0] ALU_SUB    = 8'h02;
   localparam logic [7:0] ALU_SLT    = 8'h03;
   localparam logic [7:0] ALU_SLTU   = 8'h04;
   localparam logic [7:0] ALU_AND    = 8'h05;
   localparam logic [7:0] ALU_OR     = 8'h06;
   localparam logic [7:0] ALU_XOR    = 8'h07;
   localparam logic [7:0] ALU_SLL    = 8'h08;
   localparam logic [7:0] ALU_SRL    = 8'h09;
   localparam logic [7:0] ALU_SRA    = 8'h0A;
   localparam logic [7:0] ALU_AUIPC  = ALU_ADD;
   localparam logic [7:0] ALU_MUL    = 8'h10;
   localparam logic [7:0] ALU_MULH   = 8'h11;
   localparam logic [7:0] ALU_MULHSU = 8'h12;
   localparam logic [7:0] ALU_MULHU  = 8'h13;
   localparam logic [7:0] ALU_DIV    = 8'h14;
   localparam logic [7:0] ALU_DIVU   = 8'h15;
   localparam logic [7:0] ALU_REM    = 8'h16;
   localparam logic [7:0] ALU_REMU   = 8'h17;

   localparam logic [2:0] RES_NOP    = 3'd0;
   localparam logic [2:0] RES_LOGIC  = 3'd1;
   localparam logic [2:0] RES_SHIFT  = 3'd2;
   localparam logic [2:0] RES_ARITH  = 3'd3;
   localparam logic [2:0] RES_MULDIV = 3'd4;

   localparam logic [4:0] NOP_REG_ADDR = 5'd0;
   localparam logic       RST_ENABLE   = 1'b1;
   localparam logic       READ_ENABLE  = 1'b1;
   localparam logic       READ_DISABLE = 1'b0;

   typedef enum logic {ST_RUN = 1'b0, ST_BUBBLE = 1'b1} id_state_e;

   typedef struct packed {
      logic [7:0] aluop;
      logic [2:0] alusel;
   } alu_ctl_t;

   // alt selects SUB for funct3=000 and SRA for funct3=101.
   function automatic alu_ctl_t rv32i_ctl(input logic [2:0] f3, input logic alt);
      alu_ctl_t c;
      case (f3)
         F3_ADD_SUB: c = '{alt ? ALU_SUB : ALU_ADD, RES_ARITH};
         F3_SLL:     c = '{ALU_SLL, RES_SHIFT};
         F3_SLT:     c = '{ALU_SLT, RES_ARITH};
         F3_SLTU:    c = '{ALU_SLTU, RES_ARITH};
         F3_XOR:     c = '{ALU_XOR, RES_LOGIC};
         F3_SR:      c = '{alt ? ALU_SRA : ALU_SRL, RES_SHIFT};
         F3_OR:      c = '{ALU_OR, RES_LOGIC};
         default:    c = '{ALU_AND, RES_LOGIC};
      endcase
      return c;
   endfunction

   function automatic alu_ctl_t muldiv_ctl(input logic [2:0] f3);
      alu_ctl_t c;
      case (f3)
         3'b000:  c = '{ALU_MUL, RES_MULDIV};
         3'b001:  c = '{ALU_MULH, RES_MULDIV};
         3'b010:  c = '{ALU_MULHSU, RES_MULDIV};
         3'b011:  c = '{ALU_MULHU, RES_MULDIV};
         3'b100:  c = '{ALU_DIV, RES_MULDIV};
         3'b101:  c = '{ALU_DIVU, RES_MULDIV};
         3'b110:  c = '{ALU_REM, RES_MULDIV};
         default: c = '{ALU_REMU, RES_MULDIV};
      endcase
      return c;
   endfunction

   function automatic logic is_muldiv_f7(input logic [6:0] f7);
      return f7 == F7_MULDIV;
   endfunction

endpackage

// File: rtl/id_stage_pipe_fwd_mux.sv
// Per-port operand select: immediate when the port is not read, zero for x0,
// else the youngest matching forwarding source, else the regfile value.
module id_fwd_mux #(
   parameter int XLEN    = 32,
   parameter int NUM_FWD = 2,
   parameter int REG_AW  = 5
) (
   input  logic                      re_i,
   input  logic [REG_AW-1:0]         addr_i,
   input  logic [XLEN-1:0]           rf_data_i,
   input  logic [XLEN-1:0]           imm_i,
   input  logic [NUM_FWD-1:0]        fwd_wreg_i,
   input  logic [NUM_FWD*REG_AW-1:0] fwd_wd_i,
   input  logic [NUM_FWD*XLEN-1:0]   fwd_wdata_i,
   output logic [XLEN-1:0]           data_o
);

   always_comb begin
      data_o = rf_data_i;
      // Walk oldest to youngest so the lowest matching index wins.
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
         if (fwd_wreg_i[k] && (fwd_wd_i[k*REG_AW +: REG_AW] == addr_i)) begin
            data_o = fwd_wdata_i[k*XLEN +: XLEN];
         end
      end
      if (addr_i == '0) data_o = '0;
      if (!re_i) data_o = imm_i;
   end

endmodule

// File: rtl/id_stage_pipe.sv
// RV32 decode stage with ID/EX register, operand forwarding and load-use bubbles.
// Optional macro ID_RV32M_EN enables decode of the M-extension (funct7=0000001).
module id_stage_pipe
   import id_stage_pipe_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int NUM_FWD = 2,
   parameter int REG_AW  = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      inst_valid_i,
   input  logic [XLEN-1:0]           pc_i,
   input  logic [31:0]               inst_i,
   input  logic [XLEN-1:0]           reg1_data_i,
   input  logic [XLEN-1:0]           reg2_data_i,
   input  logic [NUM_FWD-1:0]        fwd_wreg_i,
   input  logic [NUM_FWD*REG_AW-1:0] fwd_wd_i,
   input  logic [NUM_FWD*XLEN-1:0]   fwd_wdata_i,
   input  logic                      ex_is_load_i,
   input  logic                      stall_i,
   input  logic                      flush_i,
   output logic                      reg1_read_o,
   output logic                      reg2_read_o,
   output logic [REG_AW-1:0]         reg1_addr_o,
   output logic [REG_AW-1:0]         reg2_addr_o,
   output logic                      stallreq_o,
   output logic                      ex_valid_o,
   output logic [XLEN-1:0]           ex_pc_o,
   output logic [7:0]                ex_aluop_o,
   output logic [2:0]                ex_alusel_o,
   output logic [XLEN-1:0]           ex_reg1_o,
   output logic [XLEN-1:0]           ex_reg2_o,
   output logic [REG_AW-1:0]         ex_wd_o,
   output logic                      ex_wreg_o,
   output logic                      ex_illegal_o,
   output id_state_e                 dbg_state_o
);

   typedef struct packed {
      logic              valid;
      logic [XLEN-1:0]   pc;
      logic [7:0]        aluop;
      logic [2:0]        alusel;
      logic [XLEN-1:0]   reg1;
      logic [XLEN-1:0]   reg2;
      logic [REG_AW-1:0] wd;
      logic              wreg;
      logic              illegal;
   } idex_t;

   logic [6:0]        opcode;
   logic [2:0]        funct3;
   logic [6:0]        funct7;
   logic [REG_AW-1:0] rs1, rs2, rd;
   logic [XLEN-1:0]   imm_i, imm_u, shamt;
   logic              legal, alt, re1, re2;
   alu_ctl_t          ctl;
   logic [XLEN-1:0]   imm1, imm2, op1, op2;
   logic              hazard;
   id_state_e         state_q, state_d;
   idex_t             idex_q, idex_d;

   assign opcode = inst_i[6:0];
   assign funct3 = inst_i[14:12];
   assign funct7 = inst_i[31:25];
   assign rs1    = REG_AW'(inst_i[19:15]);
   assign rs2    = REG_AW'(inst_i[24:20]);
   assign rd     = REG_AW'(inst_i[11:7]);
   assign imm_i  = XLEN'($signed(inst_i[31:20]));
   assign imm_u  = XLEN'($signed({inst_i[31:12], 12'h000}));
   assign shamt  = XLEN'(inst_i[24:20]);

   always_comb begin
      legal = 1'b0;
      alt   = 1'b0;
      ctl   = '{ALU_NOP, RES_NOP};
      re1   = READ_DISABLE;
      re2   = READ_DISABLE;
      imm1  = '0;
      imm2  = '0;
      case (opcode)
         OPC_OP_IMM: begin
            re1  = READ_ENABLE;
            imm2 = imm_i;
            alt  = (funct3 == F3_SR) && inst_i[30];
            ctl  = rv32i_ctl(funct3, alt);
            case (funct3)
               F3_SLL:  legal = (funct7 == F7_BASE);
               F3_SR:   legal = (funct7 == (alt ? F7_ALT : F7_BASE));
               default: legal = 1'b1;
            endcase
            if (funct3 == F3_SLL || funct3 == F3_SR) imm2 = shamt;
         end
         OPC_OP: begin
            re1 = READ_ENABLE;
            re2 = READ_ENABLE;
            if (funct7 == F7_BASE || funct7 == F7_ALT) begin
               alt   = (funct7 == F7_ALT);
               ctl   = rv32i_ctl(funct3, alt);
               legal = !alt || funct3 == F3_ADD_SUB || funct3 == F3_SR;
            end
`ifdef ID_RV32M_EN
            else if (is_muldiv_f7(funct7)) begin
               ctl   = muldiv_ctl(funct3);
               legal = 1'b1;
            end
`endif
         end
         OPC_LUI: begin
            ctl   = '{ALU_OR, RES_LOGIC};
            imm1  = imm_u;
            legal = 1'b1;
         end
         OPC_AUIPC: begin
            ctl   = '{ALU_AUIPC, RES_ARITH};
            imm1  = pc_i;
            imm2  = imm_u;
            legal = 1'b1;
         end
         default: legal = 1'b0;
      endcase
      // Illegal instructions read nothing, so they can never raise a hazard.
      if (!legal) begin
         ctl  = '{ALU_NOP, RES_NOP};
         re1  = READ_DISABLE;
         re2  = READ_DISABLE;
         imm1 = '0;
         imm2 = '0;
      end
   end

   id_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .REG_AW(REG_AW)) u_fwd1 (
      .re_i(re1), .addr_i(rs1), .rf_data_i(reg1_data_i), .imm_i(imm1),
      .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
      .data_o(op1)
   );

   id_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .REG_AW(REG_AW)) u_fwd2 (
      .re_i(re2), .addr_i(rs2), .rf_data_i(reg2_data_i), .imm_i(imm2),
      .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
      .data_o(op2)
   );

   assign hazard = inst_valid_i && ex_is_load_i && idex_q.valid && idex_q.wreg &&
                   (idex_q.wd != REG_AW'(NOP_REG_ADDR)) &&
                   ((re1 && idex_q.wd == rs1) || (re2 && idex_q.wd == rs2));

   always_comb begin
      state_d = state_q;
      idex_d  = idex_q;
      if (flush_i) begin
         state_d = ST_RUN;
         idex_d  = '0;
      end else if (!stall_i) begin
         if (state_q == ST_RUN && hazard) begin
            state_d = ST_BUBBLE;
            idex_d  = '0;
         end else begin
            state_d = ST_RUN;
            if (inst_valid_i) begin
               idex_d = '{valid: 1'b1, pc: pc_i, aluop: ctl.aluop, alusel: ctl.alusel,
                          reg1: op1, reg2: op2,
                          wd: legal ? rd : REG_AW'(NOP_REG_ADDR),
                          wreg: legal && (rd != '0), illegal: !legal};
            end else begin
               idex_d = '0;
            end
         end
      end
   end

   // An all-zero ID/EX word is the bubble: ALU_NOP and RES_NOP both encode as 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         state_q <= ST_RUN;
         idex_q  <= '0;
      end else begin
         state_q <= state_d;
         idex_q  <= idex_d;
      end
   end

   assign reg1_read_o  = re1 && !rst;
   assign reg2_read_o  = re2 && !rst;
   assign reg1_addr_o  = rst ? '0 : rs1;
   assign reg2_addr_o  = rst ? '0 : rs2;
   assign stallreq_o   = hazard && (state_q == ST_RUN) && !rst;

   assign ex_valid_o   = idex_q.valid;
   assign ex_pc_o      = idex_q.pc;
   assign ex_aluop_o   = idex_q.aluop;
   assign ex_alusel_o  = idex_q.alusel;
   assign ex_reg1_o    = idex_q.reg1;
   assign ex_reg2_o    = idex_q.reg2;
   assign ex_wd_o      = idex_q.wd;
   assign ex_wreg_o    = idex_q.wreg;
   assign ex_illegal_o = idex_q.illegal;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed test-plan steps followed by random traffic,
// all checked against a transaction-level model of the decode stage.
`timescale 1ns/1ps
module tb_id_stage_pipe;
   import id_stage_pipe_pkg::*;

   localparam int XLEN = 32;
   localparam int NUM_FWD = 2;
   localparam int REG_AW = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_valid;
   logic [31:0] pc, inst, rf1, rf2;
   logic [1:0]  fwd_wreg;
   logic [9:0]  fwd_wd;
   logic [63:0] fwd_wdata;
   logic        ex_is_load, stall, flush;
   logic        reg1_read, reg2_read, stallreq;
   logic [4:0]  reg1_addr, reg2_addr;
   logic        ex_valid, ex_wreg, ex_illegal;
   logic [31:0] ex_pc, ex_reg1, ex_reg2;
   logic [7:0]  ex_aluop;
   logic [2:0]  ex_alusel;
   logic [4:0]  ex_wd;
   id_state_e   dbg_state;

   always #5 clk = ~clk;

   id_stage_pipe #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .REG_AW(REG_AW)) dut (
      .clk(clk), .rst(rst), .inst_valid_i(inst_valid), .pc_i(pc), .inst_i(inst),
      .reg1_data_i(rf1), .reg2_data_i(rf2), .fwd_wreg_i(fwd_wreg), .fwd_wd_i(fwd_wd),
      .fwd_wdata_i(fwd_wdata), .ex_is_load_i(ex_is_load), .stall_i(stall), .flush_i(flush),
      .reg1_read_o(reg1_read), .reg2_read_o(reg2_read), .reg1_addr_o(reg1_addr),
      .reg2_addr_o(reg2_addr), .stallreq_o(stallreq), .ex_valid_o(ex_valid), .ex_pc_o(ex_pc),
      .ex_aluop_o(ex_aluop), .ex_alusel_o(ex_alusel), .ex_reg1_o(ex_reg1), .ex_reg2_o(ex_reg2),
      .ex_wd_o(ex_wd), .ex_wreg_o(ex_wreg), .ex_illegal_o(ex_illegal), .dbg_state_o(dbg_state)
   );

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [7:0]  aluop;
      logic [2:0]  alusel;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [4:0]  wd;
      logic        wreg;
      logic        ill;
   } ex_t;

   ex_t  m;
   logic m_bub;

`ifdef ID_RV32M_EN
   logic [7:0] mtab [8] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void base_op(input logic [2:0] f3, input logic alt,
                                   output logic [7:0] op, output logic [2:0] sel);
      case (f3)
         3'd0: begin op = alt ? ALU_SUB : ALU_ADD; sel = RES_ARITH; end
         3'd1: begin op = ALU_SLL;  sel = RES_SHIFT; end
         3'd2: begin op = ALU_SLT;  sel = RES_ARITH; end
         3'd3: begin op = ALU_SLTU; sel = RES_ARITH; end
         3'd4: begin op = ALU_XOR;  sel = RES_LOGIC; end
         3'd5: begin op = alt ? ALU_SRA : ALU_SRL; sel = RES_SHIFT; end
         3'd6: begin op = ALU_OR;   sel = RES_LOGIC; end
         default: begin op = ALU_AND; sel = RES_LOGIC; end
      endcase
   endfunction

   function automatic void model_decode(input logic [31:0] ins, input logic [31:0] pcv,
      output logic re1, output logic re2, output logic ok, output logic [7:0] op,
      output logic [2:0] sel, output logic [31:0] i1, output logic [31:0] i2);
      logic [6:0] f7;
      logic [2:0] f3;
      logic       alt;
      f7 = ins[31:25];
      f3 = ins[14:12];
      re1 = 0; re2 = 0; ok = 0; op = ALU_NOP; sel = RES_NOP; i1 = 0; i2 = 0; alt = 0;
      case (ins[6:0])
         7'h13: begin
            re1 = 1;
            i2  = {{20{ins[31]}}, ins[31:20]};
            if (f3 == 3'd1 || f3 == 3'd5) i2 = {27'd0, ins[24:20]};
            ok  = !((f3 == 3'd1 && f7 != 7'h00) ||
                    (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20));
            alt = (f3 == 3'd5) && ins[30];
            base_op(f3, alt, op, sel);
         end
         7'h33: begin
            re1 = 1; re2 = 1;
            if (f7 == 7'h00) ok = 1;
            else if (f7 == 7'h20) begin ok = (f3 == 3'd0 || f3 == 3'd5); alt = 1; end
            base_op(f3, alt, op, sel);
`ifdef ID_RV32M_EN
            if (f7 == 7'h01) begin ok = 1; op = mtab[f3]; sel = RES_MULDIV; end
`endif
         end
         7'h37: begin ok = 1; op = ALU_OR; sel = RES_LOGIC; i1 = {ins[31:12], 12'h000}; end
         7'h17: begin ok = 1; op = ALU_ADD; sel = RES_ARITH; i1 = pcv; i2 = {ins[31:12], 12'h000}; end
         default: ok = 0;
      endcase
      if (!ok) begin re1 = 0; re2 = 0; op = ALU_NOP; sel = RES_NOP; i1 = 0; i2 = 0; end
   endfunction

   function automatic logic [31:0] resolve(input logic re, input logic [4:0] a,
                                           input logic [31:0] rf, input logic [31:0] imm);
      if (!re) return imm;
      if (a == 5'd0) return 32'd0;
      for (int k = 0; k < NUM_FWD; k++)
         if (fwd_wreg[k] && fwd_wd[k*5 +: 5] == a) return fwd_wdata[k*32 +: 32];
      return rf;
   endfunction

   task automatic check_ex(input string tag);
      chk({tag, ".valid"},  32'(ex_valid),   32'(m.valid));
      chk({tag, ".pc"},     ex_pc,           m.pc);
      chk({tag, ".aluop"},  32'(ex_aluop),   32'(m.aluop));
      chk({tag, ".alusel"}, 32'(ex_alusel),  32'(m.alusel));
      chk({tag, ".reg1"},   ex_reg1,         m.r1);
      chk({tag, ".reg2"},   ex_reg2,         m.r2);
      chk({tag, ".wd"},     32'(ex_wd),      32'(m.wd));
      chk({tag, ".wreg"},   32'(ex_wreg),    32'(m.wreg));
      chk({tag, ".ill"},    32'(ex_illegal), 32'(m.ill));
      chk({tag, ".state"},  32'(dbg_state),  m_bub ? 32'(ST_BUBBLE) : 32'(ST_RUN));
   endtask

   // One cycle: check comb outputs, advance the model, clock, check ID/EX.
   task automatic step(input string tag);
      logic re1, re2, ok, hz;
      logic [7:0] op;
      logic [2:0] sel;
      logic [31:0] i1, i2;
      #1;
      model_decode(inst, pc, re1, re2, ok, op, sel, i1, i2);
      hz = inst_valid && ex_is_load && m.valid && m.wreg && (m.wd != 0) &&
           ((re1 && inst[19:15] == m.wd) || (re2 && inst[24:20] == m.wd));
      chk({tag, ".stallreq"}, 32'(stallreq), 32'(hz));
      chk({tag, ".re1"}, 32'(reg1_read), 32'(re1));
      chk({tag, ".re2"}, 32'(reg2_read), 32'(re2));
      chk({tag, ".ra1"}, 32'(reg1_addr), 32'(inst[19:15]));
      chk({tag, ".ra2"}, 32'(reg2_addr), 32'(inst[24:20]));
      if (flush) begin
         m = '{default: '0}; m_bub = 0;
      end else if (!stall) begin
         if (hz) begin
            m = '{default: '0}; m_bub = 1;
         end else if (!inst_valid) begin
            m = '{default: '0}; m_bub = 0;
         end else begin
            m.valid = 1; m.pc = pc; m.aluop = op; m.alusel = sel;
            m.r1 = resolve(re1, inst[19:15], rf1, i1);
            m.r2 = resolve(re2, inst[24:20], rf2, i2);
            m.wd = ok ? inst[11:7] : 5'd0;
            m.wreg = ok && inst[11:7] != 0;
            m.ill = !ok;
            m_bub = 0;
         end
      end
      @(posedge clk);
      #1;
      check_ex(tag);
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      logic [6:0]  f7s [4];
      int pick;
      f7s = '{7'h00, 7'h20, 7'h01, 7'h7F};
      w = $urandom;
      pick = $urandom_range(0, 5);
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      w[11:7]  = 5'($urandom_range(0, 7));
      case (pick)
         0: begin w[6:0] = OPC_OP_IMM; if ($urandom_range(0, 1) == 1) w[31:25] = f7s[$urandom_range(0, 1)]; end
         1, 2: begin w[6:0] = OPC_OP; w[31:25] = f7s[$urandom_range(0, 3)]; end
         3: w[6:0] = OPC_LUI;
         4: w[6:0] = OPC_AUIPC;
         default: ;
      endcase
      return w;
   endfunction

   task automatic idle_inputs();
      inst_valid = 0; pc = 0; inst = 0; rf1 = 0; rf2 = 0;
      fwd_wreg = 0; fwd_wd = 0; fwd_wdata = 0; ex_is_load = 0; stall = 0; flush = 0;
   endtask

   logic [31:0] tbl_inst [3];
   logic [7:0]  tbl_op   [3];
   logic        tbl_ill  [3];

   initial begin
      idle_inputs();
      m = '{default: '0};
      m_bub = 0;
      rst = 1;
      #2;
      check_ex("reset");
      chk("reset.stallreq", 32'(stallreq), 32'd0);
      chk("reset.re1", 32'(reg1_read), 32'd0);
      @(posedge clk); #1;
      rst = 0;

      // ADDI x1,x0,-5
      inst_valid = 1; pc = 32'h100; inst = 32'hFFB00093; rf1 = 32'h1234; rf2 = 32'h5678;
      step("addi");
      chk("addi.reg1_k", ex_reg1, 32'h0);
      chk("addi.reg2_k", ex_reg2, 32'hFFFFFFFB);
      chk("addi.aluop_k", 32'(ex_aluop), 32'(ALU_ADD));
      chk("addi.wd_k", 32'(ex_wd), 32'd1);

      // ADD x3,x1,x2: fwd0 and fwd1 both write x1, x2 from regfile
      pc = 32'h104; inst = 32'h002081B3; rf1 = 32'hDEAD; rf2 = 32'h33;
      fwd_wreg = 2'b11; fwd_wd = {5'd1, 5'd1}; fwd_wdata = {32'h22, 32'h11};
      step("fwd");
      chk("fwd.reg1_k", ex_reg1, 32'h11);
      chk("fwd.reg2_k", ex_reg2, 32'h33);

      // stall alone: ID/EX must hold the ADD for three cycles
      inst = 32'hFFB00093; pc = 32'h108; fwd_wreg = 0; stall = 1;
      for (int i = 0; i < 3; i++) step("stall");
      chk("stall.reg1_k", ex_reg1, 32'h11);

      // flush wins over stall
      inst = 32'h002081B3; flush = 1;
      step("flush");
      chk("flush.valid_k", 32'(ex_valid), 32'd0);
      stall = 0; flush = 0;

      // load-use: x5 producer in EX marked as load, then ADD x6,x5,x5
      pc = 32'h200; inst = 32'h00100293;
      step("lu.prod");
      pc = 32'h204; inst = 32'h00528333; ex_is_load = 1;
      #1;
      chk("lu.stallreq_k", 32'(stallreq), 32'd1);
      step("lu.hz");
      chk("lu.bubble_k", 32'(ex_valid), 32'd0);
      ex_is_load = 0; fwd_wreg = 2'b10; fwd_wd = {5'd5, 5'd0}; fwd_wdata = {32'hCAFE, 32'h0};
      step("lu.fwd");
      chk("lu.reg1_k", ex_reg1, 32'hCAFE);
      chk("lu.reg2_k", ex_reg2, 32'hCAFE);
      fwd_wreg = 0;

      // DIV x7,x1,x2
      inst = 32'h0220C3B3;
      step("div");
`ifdef ID_RV32M_EN
      chk("div.aluop_k", 32'(ex_aluop), 32'(ALU_DIV));
      chk("div.ill_k", 32'(ex_illegal), 32'd0);
`else
      chk("div.ill_k", 32'(ex_illegal), 32'd1);
      chk("div.wreg_k", 32'(ex_wreg), 32'd0);
`endif

      // shift-immediate boundaries: SRAI legal, SLLI with funct7!=0 illegal, x0 dest
      tbl_inst = '{32'h4030D113, 32'h02009093, 32'h00508013};
      tbl_op   = '{ALU_SRA, ALU_NOP, ALU_ADD};
      tbl_ill  = '{1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         inst = tbl_inst[i];
         step("shimm");
         chk("shimm.aluop_k", 32'(ex_aluop), 32'(tbl_op[i]));
         chk("shimm.ill_k", 32'(ex_illegal), 32'(tbl_ill[i]));
      end
      chk("x0.wreg_k", 32'(ex_wreg), 32'd0);

      // reset in the middle of a bubble
      inst = 32'h00100293;
      step("rb.prod");
      inst = 32'h00528333; ex_is_load = 1;
      step("rb.hz");
      #2;
      rst = 1;
      #1;
      m = '{default: '0};
      m_bub = 0;
      check_ex("rb.async");
      chk("rb.stallreq", 32'(stallreq), 32'd0);
      @(posedge clk); #1;
      rst = 0;
      #1;
      chk("rb.state_k", 32'(dbg_state), 32'(ST_RUN));
      ex_is_load = 0;

      // random traffic
      for (int n = 0; n < 400; n++) begin
         inst_valid = ($urandom_range(0, 7) != 0);
         pc = $urandom & 32'hFFFF_FFFC;
         inst = rand_inst();
         rf1 = $urandom; rf2 = $urandom;
         fwd_wreg = 2'($urandom);
         fwd_wd = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         fwd_wdata = {$urandom, $urandom};
         ex_is_load = ($urandom_range(0, 2) == 0);
         stall = ($urandom_range(0, 7) == 0);
         flush = ($urandom_range(0, 15) == 0);
         step("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
